fmul_pipe: RTL and testbench

// Two-stage pipelined, flow-controlled issue/retire stage around the combinational fmul datapath.

---
 rtl/fmul_pipe_if.sv | 27 ++
 rtl/fmul_pipe.sv | 145 ++++++++++++++
 tb/tb_fmul_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_pipe_if.sv
// Operand-issue and result-retire handshake bundle between the FPU dispatcher,
// the fmul pipeline and writeback.
interface fmul_pipe_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_s;
   logic [31:0]      in_t;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_d;
   logic [TAG_W-1:0] out_tag;
   logic             out_overflow;
   logic             out_underflow;

   modport master (
      output in_valid, in_s, in_t, in_tag, out_ready,
      input  in_ready, out_valid, out_d, out_tag, out_overflow, out_underflow
   );

   modport slave (
      input  in_valid, in_s, in_t, in_tag, out_ready,
      output in_ready, out_valid, out_d, out_tag, out_overflow, out_underflow
   );
endinterface

// File: rtl/fmul_pipe.sv
// Two-stage valid/ready pipeline around a single-precision multiplier, with
// sticky overflow/underflow flags and a retired-op counter for the CSR block.
module fmul_pipe #(
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   fmul_pipe_if.slave       bus,
   input  logic             flag_clear,
   output logic             flag_overflow,
   output logic             flag_underflow,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             busy
);

   // Returns {overflow, underflow, d}. Subnormal inputs/outputs flush to zero; round to nearest even.
   function automatic logic [33:0] fmul(input logic [31:0] s, input logic [31:0] t);
      logic        sign;
      logic [7:0]  es, et;
      logic [22:0] fs, ft, frac;
      logic [47:0] prod;
      logic [23:0] rnd;
      logic        guard, sticky;
      int          e;
      sign = s[31] ^ t[31];
      es   = s[30:23];
      et   = t[30:23];
      fs   = s[22:0];
      ft   = t[22:0];
      if ((es == 8'hFF && fs != 23'd0) || (et == 8'hFF && ft != 23'd0) ||
          (es == 8'hFF && et == 8'h00) || (et == 8'hFF && es == 8'h00))
         return {2'b00, 32'h7FC0_0000};
      if (es == 8'hFF || et == 8'hFF)
         return {2'b00, sign, 8'hFF, 23'd0};
      if (es == 8'h00 || et == 8'h00)
         return {2'b00, sign, 31'd0};
      prod = {1'b1, fs} * {1'b1, ft};
      e    = int'(es) + int'(et) - 127;
      if (prod[47]) begin
         frac   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
         e      = e + 1;
      end else begin
         frac   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      rnd  = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
      frac = rnd[22:0];
      if (rnd[23])
         e = e + 1;
      if (e >= 255)
         return {2'b10, sign, 8'hFF, 23'd0};
      if (e <= 0)
         return {2'b01, sign, 31'd0};
      return {2'b00, sign, e[7:0], frac};
   endfunction

   logic             r_a_valid;
   logic [31:0]      r_a_s;
   logic [31:0]      r_a_t;
   logic [TAG_W-1:0] r_a_tag;
   logic             r_b_valid;
   logic [31:0]      r_b_d;
   logic [TAG_W-1:0] r_b_tag;
   logic             r_b_ovf;
   logic             r_b_unf;
   logic             r_flag_ovf;
   logic             r_flag_unf;
   logic [CNT_W-1:0] r_cnt;

   logic             w_b_adv;
   logic             w_a_adv;
   logic             w_retire;
   logic [33:0]      w_fm;

   assign w_b_adv  = ~r_b_valid | bus.out_ready;
   assign w_a_adv  = ~r_a_valid | w_b_adv;
   assign w_retire = r_b_valid & bus.out_ready;
   assign w_fm     = fmul(r_a_s, r_a_t);

   // Stage A: operand capture
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_a_valid <= 1'b0;
         r_a_s     <= '0;
         r_a_t     <= '0;
         r_a_tag   <= '0;
      end else if (w_a_adv) begin
         r_a_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_a_s   <= bus.in_s;
            r_a_t   <= bus.in_t;
            r_a_tag <= bus.in_tag;
         end
      end
   end

   // Stage B: product register, drives the result port directly
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_b_valid <= 1'b0;
         r_b_d     <= '0;
         r_b_tag   <= '0;
         r_b_ovf   <= 1'b0;
         r_b_unf   <= 1'b0;
      end else if (w_b_adv) begin
         r_b_valid <= r_a_valid;
         if (r_a_valid) begin
            r_b_d   <= w_fm[31:0];
            r_b_tag <= r_a_tag;
            r_b_ovf <= w_fm[33];
            r_b_unf <= w_fm[32];
         end
      end
   end

   // A clear in the same cycle as a new event leaves the flag set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_flag_ovf <= 1'b0;
         r_flag_unf <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_flag_ovf <= (r_flag_ovf & ~flag_clear) | (w_retire & r_b_ovf);
         r_flag_unf <= (r_flag_unf & ~flag_clear) | (w_retire & r_b_unf);
         if (w_retire)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready      = w_a_adv;
   assign bus.out_valid     = r_b_valid;
   assign bus.out_d         = r_b_d;
   assign bus.out_tag       = r_b_tag;
   assign bus.out_overflow  = r_b_ovf;
   assign bus.out_underflow = r_b_unf;
   assign flag_overflow     = r_flag_ovf;
   assign flag_underflow    = r_flag_unf;
   assign retired_cnt       = r_cnt;
   assign busy              = r_a_valid | r_b_valid;

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed-vector bench for fmul_pipe: table of hand-computed products plus
// sequences for back-to-back flow, stalls, sticky flags and async reset.
module tb_fmul_pipe;

   typedef struct {
      logic [31:0] s;
      logic [31:0] t;
      logic [4:0]  tag;
      logic [31:0] d;
      logic        ovf;
      logic        unf;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  tag;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        flag_clear = 1'b0;
   logic        flag_overflow, flag_underflow, busy;
   logic [15:0] retired_cnt;

   int          errors = 0;
   int          checks = 0;
   exp_t        q[$];
   vec_t        vecs[10];

   logic        prev_stall = 1'b0;
   logic [36:0] prev_out = '0;

   fmul_pipe_if #(.TAG_W(5)) bus ();

   fmul_pipe #(.TAG_W(5), .CNT_W(16)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .bus            (bus),
      .flag_clear     (flag_clear),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .retired_cnt    (retired_cnt),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.d   = v.d;
      e.tag = v.tag;
      e.ovf = v.ovf;
      e.unf = v.unf;
      return e;
   endfunction

   // Scoreboard: every handoff must match the oldest accepted op; stalled outputs must not move.
   always @(negedge clk) begin
      if (rstn && bus.out_valid) begin
         if (prev_stall)
            chk("stall_hold", {bus.out_d, bus.out_tag}, prev_out);
         if (bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_result: got d=%h tag=%0d expected no result", bus.out_d, bus.out_tag);
            end else begin
               exp_t e;
               e = q.pop_front();
               if ({bus.out_d, bus.out_tag, bus.out_overflow, bus.out_underflow} !== e) begin
                  errors++;
                  $display("FAIL result: got d=%h tag=%0d ovf=%b unf=%b expected d=%h tag=%0d ovf=%b unf=%b",
                           bus.out_d, bus.out_tag, bus.out_overflow, bus.out_underflow,
                           e.d, e.tag, e.ovf, e.unf);
               end
            end
         end
      end
      prev_stall = rstn && bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_d, bus.out_tag};
   end

   task automatic push(input vec_t v, output int waited);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_s     = v.s;
      bus.in_t     = v.t;
      bus.in_tag   = v.tag;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got in_ready=0 after %0d cycles expected 1", n);
      end else begin
         q.push_back(to_exp(v));
      end
      waited = n;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_done", {q.size() != 0, busy}, 2'b00);
   endtask

   initial begin
      int w;
      logic [15:0] cnt0;

      vecs[0] = '{32'h4000_0000, 32'h4040_0000, 5'd3,  32'h40C0_0000, 1'b0, 1'b0};
      vecs[1] = '{32'h3F80_0000, 32'h3F80_0000, 5'd1,  32'h3F80_0000, 1'b0, 1'b0};
      vecs[2] = '{32'h7F00_0000, 32'h7F00_0000, 5'd7,  32'h7F80_0000, 1'b1, 1'b0};
      vecs[3] = '{32'h0080_0000, 32'h0080_0000, 5'd9,  32'h0000_0000, 1'b0, 1'b1};
      vecs[4] = '{32'hC000_0000, 32'h4040_0000, 5'd12, 32'hC0C0_0000, 1'b0, 1'b0};
      vecs[5] = '{32'h3FC0_0000, 32'h3FC0_0000, 5'd31, 32'h4010_0000, 1'b0, 1'b0};
      vecs[6] = '{32'h0000_0000, 32'h7F00_0000, 5'd4,  32'h0000_0000, 1'b0, 1'b0};
      vecs[7] = '{32'h7F80_0000, 32'h3F80_0000, 5'd5,  32'h7F80_0000, 1'b0, 1'b0};
      vecs[8] = '{32'h3F80_0001, 32'h3FC0_0000, 5'd17, 32'h3FC0_0002, 1'b0, 1'b0};
      vecs[9] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 5'd22, 32'h407F_FFFE, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_s      = '0;
      bus.in_t      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      #12;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_flags", {flag_overflow, flag_underflow}, 2'b00);
      chk("rst_cnt", retired_cnt, 16'd0);
      #5 rstn = 1'b1;
      @(posedge clk);
      #1;

      // Single op latency
      push(vecs[0], w);
      chk("lat_a_only", {bus.out_valid, busy}, 2'b01);
      @(posedge clk);
      #1;
      chk("lat_valid", bus.out_valid, 1'b1);
      chk("lat_d", {bus.out_d, bus.out_tag, bus.out_overflow, bus.out_underflow},
          {32'h40C0_0000, 5'd3, 2'b00});
      drain();
      chk("cnt_after_one", retired_cnt, 16'd1);

      // Table: all vectors back-to-back
      for (int i = 0; i < 10; i++) begin
         push(vecs[i], w);
         chk("table_in_ready", w, 0);
      end
      drain();
      chk("cnt_after_table", retired_cnt, 16'd11);
      chk("sticky_both", {flag_overflow, flag_underflow}, 2'b11);

      // Sticky flags survive further clean ops; idle clear drops both
      push(vecs[1], w);
      drain();
      chk("sticky_held", {flag_overflow, flag_underflow}, 2'b11);
      flag_clear = 1'b1;
      @(posedge clk);
      #1;
      flag_clear = 1'b0;
      chk("idle_clear", {flag_overflow, flag_underflow}, 2'b00);

      // Four back-to-back ops retire on consecutive cycles
      cnt0 = retired_cnt;
      for (int i = 4; i < 8; i++) begin
         push(vecs[i], w);
         chk("b2b_in_ready", w, 0);
      end
      chk("b2b_mid_cnt", retired_cnt, cnt0 + 16'd2);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("b2b_cnt", retired_cnt, cnt0 + 16'd4);
      chk("b2b_idle", {bus.out_valid, busy}, 2'b00);

      // Stall: two accepted then in_ready drops for 5 cycles
      cnt0 = retired_cnt;
      bus.out_ready = 1'b0;
      push(vecs[8], w);
      push(vecs[9], w);
      chk("stall_second_accept", w, 0);
      bus.in_valid = 1'b1;
      bus.in_s     = vecs[5].s;
      bus.in_t     = vecs[5].t;
      bus.in_tag   = vecs[5].tag;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", bus.in_ready, 1'b0);
         chk("stall_out_d", {bus.out_valid, bus.out_d}, {1'b1, 32'h3FC0_0002});
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", bus.in_ready, 1'b1);
      q.push_back(to_exp(vecs[5]));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      drain();
      chk("stall_cnt", retired_cnt, cnt0 + 16'd3);

      // Clear coinciding with an overflowing retire keeps the flag
      bus.out_ready = 1'b0;
      push(vecs[2], w);
      @(posedge clk);
      #1;
      chk("ovf_waiting", {bus.out_valid, bus.out_overflow, flag_overflow}, 3'b110);
      flag_clear    = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      flag_clear = 1'b0;
      chk("clear_vs_set", flag_overflow, 1'b1);
      flag_clear = 1'b1;
      @(posedge clk);
      #1;
      flag_clear = 1'b0;
      chk("clear_idle_ovf", flag_overflow, 1'b0);

      // Asynchronous reset with two ops in flight
      push(vecs[3], w);
      drain();
      bus.out_ready = 1'b0;
      push(vecs[2], w);
      push(vecs[3], w);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_flags", {flag_overflow, flag_underflow}, 2'b00);
      chk("arst_cnt", retired_cnt, 16'd0);
      q.delete();
      @(posedge clk);
      #3;
      rstn = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      push(vecs[0], w);
      drain();
      chk("post_rst_cnt", retired_cnt, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
